// File: rtl/imm_ext_arbiter.sv
// Purpose : arbitrates two immediate requesters onto one shared 12->16 bit extender feeding a one-entry output register.
// Latency : one cycle from the accepting clock edge to out_valid with the final data.
// Backpress: a held result (out_valid=1, out_ready=0) blocks both requesters; FULL with out_ready=1 drains and refills on the same edge.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req0_valid/imm/sign, req0_ready   requester 0 (ALU immediate)
//   req1_valid/imm/sign, req1_ready   requester 1 (branch offset)
//   out_valid/out_data/out_id         registered result and owning requester
//   out_ready                         consumer takes the result this cycle
module imm_ext_arbiter #(
    parameter int RESET_PRIORITY = 0,
    parameter bit SIGN_EN        = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [11:0] req0_imm,
    input  logic        req0_sign,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_imm,
    input  logic        req1_sign,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_id,
    input  logic        out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic LP_RST_PTR = (RESET_PRIORITY != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ptr;
    logic [15:0] r_data;
    logic        r_id;

    logic        w_can_accept;
    logic        w_both;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_xfer;
    logic [11:0] w_imm;
    logic        w_sign;
    logic [15:0] w_ext;

    // Arbitration, shared extender and next-state logic.
    always_comb begin
        w_state_nxt  = r_state;
        // Readies are gated by reset so that no requester sees a handshake
        // while the block is held in reset.
        w_can_accept = reset_n && ((r_state == EMPTY) || out_ready);
        w_both       = req0_valid && req1_valid;
        w_grant0     = req0_valid && (!req1_valid || !r_ptr);
        w_grant1     = req1_valid && (!req0_valid ||  r_ptr);
        req0_ready   = w_can_accept && w_grant0;
        req1_ready   = w_can_accept && w_grant1;
        w_xfer       = req0_ready || req1_ready;

        w_imm        = w_grant1 ? req1_imm  : req0_imm;
        w_sign       = w_grant1 ? req1_sign : req0_sign;
        if (w_sign && SIGN_EN) begin
            w_ext = {{4{w_imm[11]}}, w_imm};
        end else begin
            w_ext = {4'b0000, w_imm};
        end

        if (w_xfer) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && out_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_ptr   <= LP_RST_PTR;
            r_data  <= 16'h0000;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_data <= w_ext;
                r_id   <= w_grant1;
                // Priority only rotates when there was actual contention.
                if (w_both) begin
                    r_ptr <= ~r_ptr;
                end
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_id    = r_id;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_sign, req1_valid, req1_sign, out_ready;
    logic [11:0] req0_imm, req1_imm;

    logic        s_r0, s_r1, s_ov, s_id;
    logic [15:0] s_od;
    logic        z_r0, z_r1, z_ov, z_id;
    logic [15:0] z_od;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        id;
        logic [15:0] ds;   // expected with sign extension enabled
        logic [15:0] dz;   // expected with sign extension disabled
    } exp_t;

    exp_t sb[$];

    // reference model state
    bit m_full = 1'b0;
    int m_fav  = 0;

    always #5 clk = ~clk;

    imm_ext_arbiter #(.RESET_PRIORITY(0), .SIGN_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_sign(req0_sign), .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_sign(req1_sign), .req1_ready(s_r1),
        .out_valid(s_ov), .out_data(s_od), .out_id(s_id), .out_ready(out_ready)
    );

    imm_ext_arbiter #(.RESET_PRIORITY(0), .SIGN_EN(1'b0)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_sign(req0_sign), .req0_ready(z_r0),
        .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_sign(req1_sign), .req1_ready(z_r1),
        .out_valid(z_ov), .out_data(z_od), .out_id(z_id), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // value of the 12-bit field read as unsigned or two's complement, in 16 bits
    function automatic logic [15:0] ext_val(input logic [11:0] imm, input bit as_signed);
        int v;
        v = int'(imm);
        if (as_signed && v >= 2048) v = v - 4096;
        return 16'(v);
    endfunction

    // Monitor: whenever a result is presented it must match the oldest
    // outstanding expectation; it is retired when the consumer takes it.
    always @(negedge clk) begin
        if (reset_n && s_ov) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(s_od), 32'hFFFF_FFFF);
            end else begin
                chk("out_id",      32'(s_id), 32'(sb[0].id));
                chk("out_data",    32'(s_od), 32'(sb[0].ds));
                chk("z_out_id",    32'(z_id), 32'(sb[0].id));
                chk("z_out_data",  32'(z_od), 32'(sb[0].dz));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus: drive, check handshake against the model at the
    // falling edge, advance the model for the coming rising edge.
    task automatic step(input bit v0, input logic [11:0] i0, input bit g0,
                        input bit v1, input logic [11:0] i1, input bit g1,
                        input bit ordy);
        bit   can;
        int   win;
        exp_t e;
        req0_valid = v0; req0_imm = i0; req0_sign = g0;
        req1_valid = v1; req1_imm = i1; req1_sign = g1;
        out_ready  = ordy;
        @(negedge clk);
        can = !m_full || ordy;
        win = -1;
        if (v0 && v1)  win = m_fav;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
        if (!can) win = -1;
        chk("out_valid",   32'(s_ov), 32'(m_full));
        chk("z_out_valid", 32'(z_ov), 32'(m_full));
        chk("req0_ready",  32'(s_r0), 32'(win == 0));
        chk("req1_ready",  32'(s_r1), 32'(win == 1));
        chk("z_req0_ready", 32'(z_r0), 32'(win == 0));
        chk("z_req1_ready", 32'(z_r1), 32'(win == 1));
        if (win >= 0) begin
            e.id = (win == 1);
            e.ds = (win == 1) ? ext_val(i1, g1) : ext_val(i0, g0);
            e.dz = (win == 1) ? ext_val(i1, 1'b0) : ext_val(i0, 1'b0);
            sb.push_back(e);
            m_full = 1'b1;
            if (v0 && v1) m_fav = 1 - m_fav;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 0; req0_imm = '0; req0_sign = 0;
        req1_valid = 0; req1_imm = '0; req1_sign = 0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_out_data",  32'(s_od), 32'd0);
        chk("rst_out_id",    32'(s_id), 32'd0);
        reset_n = 1'b1;

        // single requesters, extension variants
        step(1, 12'h003, 0, 0, 12'h000, 0, 1);
        step(0, 12'h000, 0, 1, 12'hFFF, 1, 1);
        step(0, 12'h000, 0, 1, 12'hFFF, 0, 1);
        step(0, 12'h000, 0, 1, 12'h800, 1, 1);
        step(0, 12'h000, 0, 0, 12'h000, 0, 1);

        // contention: alternating winners, one result per cycle
        for (int k = 0; k < 6; k++) step(1, 12'(k), 0, 1, 12'(12'h100 + k), 1, 1);
        step(0, 12'h000, 0, 0, 12'h000, 0, 1);

        // held result with both requesters pending, then drain and refill
        step(1, 12'h01B, 0, 0, 12'h000, 0, 0);
        repeat (3) step(1, 12'h0AA, 0, 1, 12'hBBB, 1, 0);
        step(1, 12'h0AA, 0, 1, 12'hBBB, 1, 1);
        step(0, 12'h000, 0, 0, 12'h000, 0, 1);

        // accepted while EMPTY with out_ready low, held until taken
        step(1, 12'h005, 0, 0, 12'h000, 0, 0);
        repeat (2) step(0, 12'h000, 0, 0, 12'h000, 0, 0);
        step(0, 12'h000, 0, 0, 12'h000, 0, 1);

        // asynchronous reset pulse mid-cycle while FULL
        step(1, 12'h7FF, 1, 1, 12'h123, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(s_ov), 32'd0);
        chk("arst_out_data",  32'(s_od), 32'd0);
        chk("arst_out_id",    32'(s_id), 32'd0);
        chk("arst_req0_rdy",  32'(s_r0), 32'd0);
        chk("arst_z_data",    32'(z_od), 32'd0);
        sb.delete();
        m_full = 1'b0;
        m_fav  = 0;
        #1 reset_n = 1'b1;
        // first edge after reset accepts, priority back at requester 0
        step(1, 12'h044, 0, 1, 12'h055, 0, 1);
        step(1, 12'h044, 0, 1, 12'h055, 0, 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 60, 12'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 60, 12'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 70);
        end

        // drain
        repeat (3) step(0, 12'h000, 0, 0, 12'h000, 0, 1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 The block SHALL have parameter RESET_PRIORITY, default 0, meaning the requester index favoured first after reset.
REQ-002 The block SHALL have parameter SIGN_EN, default 1, meaning sign extension is enabled; when 0, every request is zero-extended.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port req0_valid  input  1  requester 0 (ALU immediate) has a request.
REQ-007 Port req0_imm  input  12  requester 0 immediate field.
REQ-008 Port req0_sign  input  1  requester 0: 1 = sign-extend, 0 = zero-extend.
REQ-009 Port req0_ready  output  1  requester 0 request accepted this cycle.
REQ-010 Port req1_valid  input  1  requester 1 (branch offset) has a request.
REQ-011 Port req1_imm  input  12  requester 1 immediate field.
REQ-012 Port req1_sign  input  1  requester 1: 1 = sign-extend, 0 = zero-extend.
REQ-013 Port req1_ready  output  1  requester 1 request accepted this cycle.
REQ-014 Port out_valid  output  1  out_data/out_id hold a result.
REQ-015 Port out_data  output  16  extended immediate.
REQ-016 Port out_id  output  1  index of the requester that owns out_data.
REQ-017 Port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-018 The block SHALL contain one shared extender and a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 can_accept SHALL be 1 when EMPTY, or when FULL and out_ready=1 in the same cycle (pass-through drain and refill).
REQ-020 Arbitration: one valid requester -> granted; both valid -> requester equal to the priority pointer granted; none valid -> no grant.
REQ-021 reqN_ready SHALL equal can_accept AND grantN; it is combinational and never high for both requesters.
REQ-022 A request transfers on a rising edge where reqN_valid=1 and reqN_ready=1; on transfer, out_valid=1 and out_id=N from the next cycle.
REQ-023 The priority pointer SHALL change to the other requester only after a transfer that occurred while both were valid; otherwise it holds.
REQ-024 Zero extension: out_data = {4'b0000, imm}; sign extension (sign=1, SIGN_EN=1): out_data = {4{imm[11]}, imm}.
REQ-025 Latency SHALL be exactly one cycle from transfer edge to out_valid=1 with the final data.
REQ-026 While FULL and out_ready=0, out_valid, out_data and out_id SHALL hold stable and both reqN_ready SHALL be 0.
REQ-027 FULL with out_ready=1 and no transfer -> EMPTY next cycle; out_data holds its last value.
REQ-028 Requester valid and data SHALL be sampled only on the transfer edge; changes on other cycles have no effect.
REQ-029 out_ready while EMPTY SHALL be ignored.

Reset
REQ-030 reset_n=0 SHALL immediately force out_valid=0, out_data=16'h0000, out_id=0, pointer=RESET_PRIORITY, state EMPTY, regardless of clk.
REQ-031 A result pending when reset asserts SHALL be discarded; no transfer occurs on any edge while reset_n=0.
REQ-032 After reset_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-033 req0 only, imm=12'h003, sign=0, out_ready=1 -> next cycle out_valid=1, out_data=16'h0003, out_id=0.
REQ-034 req1 only, imm=12'hFFF, sign=1 -> out_data=16'hFFFF; same with sign=0 -> 16'h0FFF; SIGN_EN=0, sign=1 -> 16'h0FFF.
REQ-035 Both valid continuously, out_ready=1, RESET_PRIORITY=0 -> out_id sequence 0,1,0,1 on consecutive cycles, one result per cycle.
REQ-036 FULL with out_data=16'h001B, out_ready=0 for 3 cycles -> outputs stable, both ready=0; out_ready=1 -> pending req accepted same edge.
REQ-037 reset_n pulsed low mid-clock while FULL -> out_valid=0 and out_data=16'h0000 without a clock edge; pointer=RESET_PRIORITY.
REQ-038 req0 valid, imm=12'h005, out_ready=0 while EMPTY -> accepted; next cycle out_data=16'h0005 held until out_ready=1.
